// File: rtl/traffic_lamp_driver.sv
// Drives one-hot red/yellow/green lamps for NUM_CH approaches from 2-bit colour codes.
// Supports night flashing, a timed lamp test and a latching conflict/invalid-code monitor.
module traffic_lamp_driver #(
    parameter int NUM_CH      = 2,
    parameter int BLINK_DIV   = 25000000,
    parameter int LT_STEP     = 50000000,
    parameter int VIOL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*NUM_CH-1:0]   color_in,
    input  logic                  flash_req,
    input  logic                  lamp_test_start,
    input  logic                  fault_clear,
    output logic [NUM_CH-1:0]     red,
    output logic [NUM_CH-1:0]     yellow,
    output logic [NUM_CH-1:0]     green,
    output logic                  fault,
    output logic                  lamp_test_busy
);

    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int LW = (LT_STEP > 1) ? $clog2(LT_STEP) : 1;
    localparam int VW = $clog2(VIOL_CYCLES + 1);

    localparam logic [1:0] C_RED     = 2'd0;
    localparam logic [1:0] C_YELLOW  = 2'd1;
    localparam logic [1:0] C_GREEN   = 2'd2;
    localparam logic [1:0] C_INVALID = 2'd3;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [LW-1:0] LT_LAST    = LW'(LT_STEP - 1);
    localparam logic [VW-1:0] VIOL_LAST  = VW'(VIOL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_FLASH     = 2'd1,
        ST_LAMP_TEST = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        LT_RED    = 2'd0,
        LT_YELLOW = 2'd1,
        LT_GREEN  = 2'd2
    } lt_step_t;

    state_t            state_reg, state_next;
    lt_step_t          lt_step_reg, lt_step_next;
    logic [LW-1:0]     lt_cnt_reg, lt_cnt_next;
    logic [BW-1:0]     blink_cnt_reg, blink_cnt_next;
    logic              blink_phase_reg, blink_phase_next;
    logic [VW-1:0]     viol_cnt_reg, viol_cnt_next;
    logic [1:0]        held_reg [NUM_CH];
    logic [1:0]        held_next [NUM_CH];

    logic [1:0]        code [NUM_CH];
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] invalid;
    logic              multi_active;
    logic              violation;
    logic              monitored;
    logic              blink_entry;

    logic [NUM_CH-1:0] red_next, yellow_next, green_next;
    logic              fault_next, busy_next;

    // Per-channel decode and held-colour update; code 3 keeps the last valid colour.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign code[gi]    = color_in[2*gi +: 2];
            assign active[gi]  = (code[gi] == C_YELLOW) || (code[gi] == C_GREEN);
            assign invalid[gi] = (code[gi] == C_INVALID);
            assign held_next[gi] = ((state_reg != ST_LAMP_TEST) && !invalid[gi])
                                   ? code[gi] : held_reg[gi];
        end
    endgenerate

    // Clearing the lowest set bit leaves something only if two or more channels are active.
    assign multi_active = |(active & (active - NUM_CH'(1)));
    assign violation    = multi_active || (|invalid);
    assign monitored    = (state_reg == ST_NORMAL) || (state_reg == ST_FLASH);

    always_comb begin
        state_next    = state_reg;
        lt_step_next  = lt_step_reg;
        lt_cnt_next   = lt_cnt_reg;
        viol_cnt_next = '0;

        case (state_reg)
            ST_NORMAL, ST_FLASH: begin
                viol_cnt_next = violation ? (viol_cnt_reg + VW'(1)) : '0;
                if (violation && (viol_cnt_reg == VIOL_LAST)) begin
                    state_next    = ST_FAULT;
                    viol_cnt_next = '0;
                end else if (lamp_test_start) begin
                    state_next   = ST_LAMP_TEST;
                    lt_step_next = LT_RED;
                    lt_cnt_next  = '0;
                end else begin
                    state_next = flash_req ? ST_FLASH : ST_NORMAL;
                end
            end
            ST_LAMP_TEST: begin
                if (lt_cnt_reg == LT_LAST) begin
                    lt_cnt_next = '0;
                    case (lt_step_reg)
                        LT_RED:    lt_step_next = LT_YELLOW;
                        LT_YELLOW: lt_step_next = LT_GREEN;
                        default:   state_next   = flash_req ? ST_FLASH : ST_NORMAL;
                    endcase
                end else begin
                    lt_cnt_next = lt_cnt_reg + LW'(1);
                end
            end
            ST_FAULT: begin
                if (fault_clear && !violation) begin
                    state_next = flash_req ? ST_FLASH : ST_NORMAL;
                end
            end
            default: state_next = ST_NORMAL;
        endcase
    end

    // Restarting the blink timer on entry guarantees the first half-period is lit.
    assign blink_entry = ((state_next == ST_FLASH) && (state_reg != ST_FLASH)) ||
                         ((state_next == ST_FAULT) && (state_reg != ST_FAULT));

    always_comb begin
        blink_cnt_next   = blink_cnt_reg + BW'(1);
        blink_phase_next = blink_phase_reg;
        if (blink_entry) begin
            blink_cnt_next   = '0;
            blink_phase_next = 1'b1;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next   = '0;
            blink_phase_next = ~blink_phase_reg;
        end
    end

    // Lamp drive is decoded from next-state values so the outputs can be registered.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lamp
            logic normal_mode, flash_lit, fault_lit, lt_mode;
            assign normal_mode = (state_next == ST_NORMAL);
            assign flash_lit   = (state_next == ST_FLASH) && blink_phase_next;
            assign fault_lit   = (state_next == ST_FAULT) && blink_phase_next;
            assign lt_mode     = (state_next == ST_LAMP_TEST);

            if (gi == 0) begin : g_main
                assign red_next[gi]    = (normal_mode && (held_next[gi] == C_RED)) ||
                                         fault_lit || (lt_mode && (lt_step_next == LT_RED));
                assign yellow_next[gi] = (normal_mode && (held_next[gi] == C_YELLOW)) ||
                                         flash_lit || (lt_mode && (lt_step_next == LT_YELLOW));
            end else begin : g_side
                assign red_next[gi]    = (normal_mode && (held_next[gi] == C_RED)) ||
                                         flash_lit || fault_lit ||
                                         (lt_mode && (lt_step_next == LT_RED));
                assign yellow_next[gi] = (normal_mode && (held_next[gi] == C_YELLOW)) ||
                                         (lt_mode && (lt_step_next == LT_YELLOW));
            end
            assign green_next[gi] = (normal_mode && (held_next[gi] == C_GREEN)) ||
                                    (lt_mode && (lt_step_next == LT_GREEN));
        end
    endgenerate

    assign fault_next = (state_next == ST_FAULT);
    assign busy_next  = (state_next == ST_LAMP_TEST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_NORMAL;
            lt_step_reg     <= LT_RED;
            lt_cnt_reg      <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
            viol_cnt_reg    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                held_reg[i] <= C_RED;
            end
            red            <= '1;
            yellow         <= '0;
            green          <= '0;
            fault          <= 1'b0;
            lamp_test_busy <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lt_step_reg     <= lt_step_next;
            lt_cnt_reg      <= lt_cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
            viol_cnt_reg    <= viol_cnt_next;
            for (int i = 0; i < NUM_CH; i++) begin
                held_reg[i] <= held_next[i];
            end
            red            <= red_next;
            yellow         <= yellow_next;
            green          <= green_next;
            fault          <= fault_next;
            lamp_test_busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// Bench for traffic_lamp_driver: directed scenarios plus randomized traffic, all outputs
// compared each cycle against a time-based behavioural model.
module tb_traffic_lamp_driver;

    localparam int NUM_CH      = 2;
    localparam int BLINK_DIV   = 4;
    localparam int LT_STEP     = 3;
    localparam int VIOL_CYCLES = 2;

    localparam int M_NORMAL = 0;
    localparam int M_FLASH  = 1;
    localparam int M_LT     = 2;
    localparam int M_FAULT  = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [2*NUM_CH-1:0] color_in = '0;
    logic                flash_req = 1'b0;
    logic                lamp_test_start = 1'b0;
    logic                fault_clear = 1'b0;
    logic [NUM_CH-1:0]   red, yellow, green;
    logic                fault, lamp_test_busy;

    traffic_lamp_driver #(
        .NUM_CH(NUM_CH), .BLINK_DIV(BLINK_DIV), .LT_STEP(LT_STEP), .VIOL_CYCLES(VIOL_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .color_in(color_in), .flash_req(flash_req),
        .lamp_test_start(lamp_test_start), .fault_clear(fault_clear),
        .red(red), .yellow(yellow), .green(green),
        .fault(fault), .lamp_test_busy(lamp_test_busy)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode plus timestamps of entry; lamp patterns derived from elapsed edges.
    int                m_mode;
    int                m_held [NUM_CH];
    int                m_run;
    int                m_n;
    int                m_blink_t0;
    int                m_lt_t0;
    logic [NUM_CH-1:0] e_red, e_yel, e_grn;
    logic              e_fault, e_busy;

    task automatic model_reset();
        m_mode = M_NORMAL;
        for (int i = 0; i < NUM_CH; i++) m_held[i] = 0;
        m_run   = 0;
        e_red   = '1;
        e_yel   = '0;
        e_grn   = '0;
        e_fault = 1'b0;
        e_busy  = 1'b0;
    endtask

    task automatic model_step(input logic [2*NUM_CH-1:0] col, input logic fl,
                              input logic lts, input logic fc);
        int  codes [NUM_CH];
        int  nact;
        bit  bad;
        int  old_mode;
        int  new_mode;
        bit  lit;
        int  step;
        nact = 0;
        bad  = 0;
        m_n++;
        for (int i = 0; i < NUM_CH; i++) begin
            codes[i] = int'(col[2*i +: 2]);
            if (codes[i] == 1 || codes[i] == 2) nact++;
            if (codes[i] == 3) bad = 1;
        end
        if (nact >= 2) bad = 1;
        old_mode = m_mode;
        if (old_mode != M_LT)
            for (int i = 0; i < NUM_CH; i++) if (codes[i] != 3) m_held[i] = codes[i];
        new_mode = old_mode;
        case (old_mode)
            M_NORMAL, M_FLASH: begin
                m_run = bad ? m_run + 1 : 0;
                if (m_run >= VIOL_CYCLES) new_mode = M_FAULT;
                else if (lts) begin new_mode = M_LT; m_lt_t0 = m_n; end
                else new_mode = fl ? M_FLASH : M_NORMAL;
            end
            M_LT:    if (m_n - m_lt_t0 >= 3 * LT_STEP) new_mode = fl ? M_FLASH : M_NORMAL;
            default: if (fc && !bad) new_mode = fl ? M_FLASH : M_NORMAL;
        endcase
        if (new_mode == M_FAULT || new_mode == M_LT) m_run = 0;
        if ((new_mode == M_FLASH || new_mode == M_FAULT) && new_mode != old_mode) m_blink_t0 = m_n;
        m_mode = new_mode;

        lit = (((m_n - m_blink_t0) / BLINK_DIV) % 2) == 0;
        e_red = '0; e_yel = '0; e_grn = '0;
        case (m_mode)
            M_NORMAL: for (int i = 0; i < NUM_CH; i++) begin
                e_red[i] = (m_held[i] == 0);
                e_yel[i] = (m_held[i] == 1);
                e_grn[i] = (m_held[i] == 2);
            end
            M_FLASH: for (int i = 0; i < NUM_CH; i++) begin
                if (i == 0) e_yel[i] = lit;
                else        e_red[i] = lit;
            end
            M_LT: begin
                step = (m_n - m_lt_t0) / LT_STEP;
                if (step == 0) e_red = '1;
                else if (step == 1) e_yel = '1;
                else e_grn = '1;
            end
            default: if (lit) e_red = '1;
        endcase
        e_fault = (m_mode == M_FAULT);
        e_busy  = (m_mode == M_LT);
    endtask

    // One transaction: drive at a falling edge, model the rising edge, compare just after it.
    task automatic run_cycle(input logic [2*NUM_CH-1:0] col, input logic fl,
                             input logic lts, input logic fc);
        color_in        = col;
        flash_req       = fl;
        lamp_test_start = lts;
        fault_clear     = fc;
        @(posedge clk);
        model_step(col, fl, lts, fc);
        #1;
        check("red",    32'(red),            32'(e_red));
        check("yellow", 32'(yellow),         32'(e_yel));
        check("green",  32'(green),          32'(e_grn));
        check("fault",  32'(fault),          32'(e_fault));
        check("busy",   32'(lamp_test_busy), 32'(e_busy));
        $display("[TB] cyc %0d col=%b fl=%b lts=%b fc=%b -> r=%b y=%b g=%b fault=%b busy=%b",
                 m_n, col, fl, lts, fc, red, yellow, green, fault, lamp_test_busy);
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_red"},    32'(red),            32'h3);
        check({tag, "_yellow"}, 32'(yellow),         32'h0);
        check({tag, "_green"},  32'(green),          32'h0);
        check({tag, "_busy"},   32'(lamp_test_busy), 32'h0);
        check({tag, "_fault"},  32'(fault),          32'h0);
        $display("[TB] async reset (%s) -> r=%b y=%b g=%b fault=%b busy=%b",
                 tag, red, yellow, green, fault, lamp_test_busy);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2*NUM_CH-1:0] col;
        logic                fl;
        int                  r;
        model_reset();
        m_n = 0;
        m_blink_t0 = 0;
        m_lt_t0 = 0;
        repeat (2) @(negedge clk);
        check("rst_red",   32'(red),            32'h3);
        check("rst_green", 32'(green),          32'h0);
        check("rst_fault", 32'(fault),          32'h0);
        check("rst_busy",  32'(lamp_test_busy), 32'h0);
        rst_n = 1'b1;

        // Normal decode and invalid-code hold
        run_cycle(4'b1000, 0, 0, 0);
        check("p1_red", 32'(red), 32'h1);
        check("p1_green", 32'(green), 32'h2);
        run_cycle(4'b1011, 0, 0, 0);
        check("p1_hold_red", 32'(red), 32'h1);
        run_cycle(4'b1000, 0, 0, 0);
        check("p1_fault", 32'(fault), 32'h0);

        // Flashing mode
        for (int k = 0; k < 8; k++) begin
            run_cycle(4'b1000, 1, 0, 0);
            check("p2_yel0", 32'(yellow[0]), 32'(k < 4));
            check("p2_red1", 32'(red[1]),    32'(k < 4));
            check("p2_green", 32'(green),    32'h0);
        end
        run_cycle(4'b1000, 0, 0, 0);
        check("p2_back_red", 32'(red), 32'h1);
        check("p2_back_green", 32'(green), 32'h2);

        // Conflicting greens latch a fault
        run_cycle(4'b1010, 0, 0, 0);
        check("p3_nofault", 32'(fault), 32'h0);
        run_cycle(4'b1010, 0, 0, 0);
        check("p3_fault", 32'(fault), 32'h1);
        check("p3_red0", 32'(red), 32'h3);
        for (int k = 1; k < 8; k++) begin
            run_cycle(4'b1010, 0, 0, 0);
            check("p3_redflash", 32'(red), (k < 4) ? 32'h3 : 32'h0);
        end
        run_cycle(4'b1010, 0, 0, 1);
        check("p3_clr_ignored", 32'(fault), 32'h1);
        run_cycle(4'b0010, 0, 0, 1);
        check("p3_cleared", 32'(fault), 32'h0);
        check("p3_green", 32'(green), 32'h1);

        // Lamp test with a redundant start pulse
        run_cycle(4'b0010, 0, 1, 0);
        check("p4_busy", 32'(lamp_test_busy), 32'h1);
        check("p4_red", 32'(red), 32'h3);
        for (int k = 1; k < 9; k++) begin
            run_cycle(4'b0010, 0, (k == 4), 0);
            check("p4_lt_red",    32'(red),    (k < 3) ? 32'h3 : 32'h0);
            check("p4_lt_yellow", 32'(yellow), (k >= 3 && k < 6) ? 32'h3 : 32'h0);
            check("p4_lt_green",  32'(green),  (k >= 6) ? 32'h3 : 32'h0);
        end
        run_cycle(4'b0010, 0, 0, 0);
        check("p4_done", 32'(lamp_test_busy), 32'h0);
        check("p4_green", 32'(green), 32'h1);

        // Asynchronous reset in the middle of a lamp test
        run_cycle(4'b0010, 0, 1, 0);
        run_cycle(4'b0010, 0, 0, 0);
        async_reset("p5");

        // Fault threshold coincides with a lamp test request
        run_cycle(4'b1010, 0, 0, 0);
        run_cycle(4'b1010, 0, 1, 0);
        check("p6_fault", 32'(fault), 32'h1);
        check("p6_busy", 32'(lamp_test_busy), 32'h0);
        run_cycle(4'b0000, 0, 0, 1);
        check("p6_cleared", 32'(fault), 32'h0);

        // Randomized traffic
        fl = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            r = int'($urandom_range(0, 99));
            col = '0;
            if (r < 60) begin
                col[2*$urandom_range(0, NUM_CH-1) +: 2] = 2'($urandom_range(0, 2));
            end else if (r < 85) begin
                for (int i = 0; i < NUM_CH; i++) col[2*i +: 2] = 2'($urandom_range(0, 2));
            end else begin
                col = (2*NUM_CH)'($urandom);
            end
            if ($urandom_range(0, 39) == 0) fl = ~fl;
            if ($urandom_range(0, 499) == 0) begin
                async_reset("rnd_rst");
            end else begin
                run_cycle(col, fl, ($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/traffic_lamp_driver.md
Name: traffic_lamp_driver

Overview:
- Parametrised successor of the two-approach lamp decoder: registers 2-bit colour codes for NUM_CH approaches into one-hot red/yellow/green lamp drives.
- Adds flashing (night) mode, a timed lamp-test sequence, and a safety monitor that latches a fault on conflicting greens or invalid codes and forces all-red flashing.
- Sits between the intersection sequencer (colour codes) and the board LED/lamp pins.

Parameters:
- NUM_CH, 2, number of approaches; channel 0 is main.
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).
- LT_STEP, 50000000, clk cycles each lamp-test colour is held (>=1).
- VIOL_CYCLES, 2, consecutive violating cycles before the fault latches (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- color_in  in  2*NUM_CH  colour code per channel; ch i = [2i+1:2i]; RED=0, YELLOW=1, GREEN=2, 3=invalid
- flash_req  in  1  level; request flashing mode
- lamp_test_start  in  1  single-cycle pulse; start lamp test
- fault_clear  in  1  single-cycle pulse; clear latched fault
- red  out  NUM_CH  red lamp per channel, ON=1
- yellow  out  NUM_CH  yellow lamp per channel
- green  out  NUM_CH  green lamp per channel
- fault  out  1  latched safety fault
- lamp_test_busy  out  1  high during lamp test

Behaviour:
- Reset is asynchronous and active-low: red = all 1, yellow = green = 0, fault = 0, lamp_test_busy = 0, state NORMAL, blink counter = 0, blink_phase = 1, per-channel held colour = RED, violation counter = 0.
- All outputs registered. At most one lamp per channel is on at any time.
- State priority: FAULT > LAMP_TEST > FLASH > NORMAL.
- NORMAL:
  - Lamps follow color_in with 1-cycle latency.
  - Code 3 on a channel holds that channel's previous valid colour.
  - Go to FLASH when flash_req=1.
- FLASH:
  - Channel 0 flashes yellow; all other channels flash red. Lamp is on when blink_phase=1.
  - Return to NORMAL on the cycle after flash_req=0.
- Blink timer:
  - Counts 0..BLINK_DIV-1. blink_phase toggles on wrap.
  - On entry to FLASH or FAULT, counter = 0 and phase = 1, so the first half-period is lit.
- Violation:
  - Occurs in a cycle when two or more channels have a code in {YELLOW, GREEN}, or any channel has code 3.
  - Monitored in NORMAL and FLASH only.
  - Counter increments per violating cycle and resets to 0 on any clean cycle.
  - When the counter reaches VIOL_CYCLES, the next state is FAULT and fault=1.
  - Counter is forced to 0 in LAMP_TEST and FAULT.
- FAULT:
  - All channels flash red; yellow and green are 0.
  - fault stays 1 until fault_clear=1 in a cycle with no violation present.
  - On clear, fault=0 on the next cycle and the state goes to FLASH if flash_req=1, else NORMAL.
  - fault_clear while a violation is present is ignored. lamp_test_start is ignored.
- LAMP_TEST:
  - Entered from NORMAL or FLASH on lamp_test_start; lamp_test_busy=1 on the next cycle.
  - Sub-steps: all red on, then all yellow on, then all green on, each for exactly LT_STEP cycles.
  - After the last step: busy=0, and the state is FLASH or NORMAL per flash_req.
  - lamp_test_start while busy is ignored (no restart). color_in is ignored; held colours are not updated.
- Simultaneous events:
  - lamp_test_start in the same cycle that the violation counter reaches VIOL_CYCLES: FAULT wins.
  - fault_clear outside FAULT has no effect.
- rst_n asserted mid-operation (any state, including mid lamp test): immediate return to reset values.

Test Plan:
Bench parameters: NUM_CH=2, BLINK_DIV=4, LT_STEP=3, VIOL_CYCLES=2.
1. Release reset, hold color_in=2'b10_00 (ch1 GREEN, ch0 RED) -> red=2'b01 and green=2'b10 one cycle after the code is applied. Then apply ch0=3 for 1 cycle, then restore -> ch0 stays red, fault=0.
2. flash_req=1 -> yellow[0] pattern 1,1,1,1,0,0,0,0 repeating from the entry cycle; red[1] follows the same pattern; green=0. Drop flash_req -> NORMAL lamps return next cycle.
3. color_in=2'b10_10 (both GREEN) for 2 cycles -> fault=1, then red=2'b11 flashing 4 on / 4 off. Pulse fault_clear while still both GREEN -> fault stays 1. Set codes to 2'b00_10, pulse fault_clear -> fault=0, NORMAL, green=2'b01.
4. Pulse lamp_test_start in NORMAL -> busy=1; red=2'b11 for 3 cycles, then yellow=2'b11 for 3, then green=2'b11 for 3; then busy=0. A second start pulse mid-test changes nothing.
5. Assert rst_n=0 mid lamp test, asynchronously (not on a clock edge) -> red=2'b11, yellow=green=0, busy=0, fault=0 immediately.
6. Violation counter reaching 2 in the same cycle as lamp_test_start -> FAULT entered, busy stays 0.
